alu_operand_seq: RTL and testbench

Operand-entry and result-capture sequencer that drives the 4-bit ALU from board inputs. It debounces one push-button and steps through loading operand A, operand B and the opcode from switches. It then presents `a`/`b`/`s` to the ALU and registers the ALU's `y`/`cf`/`of`/`zf` into a held result with a valid flag. It supports accumulator chaining, where the previous result becomes the next operand A.

---
 rtl/alu_operand_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_operand_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_seq.sv
// Purpose : debounced push-button sequencer loading A, B and opcode for a 4-bit ALU, then capturing its result.
// Latency : the FSM acts 4+DB_CYCLES edges after btn is first sampled high; LOAD_S press to valid=1 is 2 edges.
// Backpr. : none; a press arriving while EXEC is active is dropped, not queued.
//
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   btn                         - raw bouncing push-button
//   din[3:0], op_in[2:0], chain - switch inputs (operand, opcode, result->A select)
//   y_in, cf_in, of_in, zf_in   - combinational ALU result and flags
//   a, b, s                     - registered operands/opcode driving the ALU
//   res, cf, of, zf, valid      - captured result, flags and its valid flag
//   state                       - current FSM state for LEDs
module alu_operand_seq #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic [3:0] din,
    input  logic [2:0] op_in,
    input  logic       chain,
    input  logic [3:0] y_in,
    input  logic       cf_in,
    input  logic       of_in,
    input  logic       zf_in,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] s,
    output logic [3:0] res,
    output logic       cf,
    output logic       of,
    output logic       zf,
    output logic       valid,
    output logic [2:0] state
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        LOAD_S = 3'd2,
        EXEC   = 3'd3,
        SHOW   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             btn_meta_q, btn_meta_d;
    logic             btn_s_q, btn_s_d;
    logic             btn_clean_q, btn_clean_d;
    logic             btn_clean_dly_q, btn_clean_dly_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             press_q, press_d;
    logic [3:0]       a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]       s_q, s_d;
    logic             cf_q, cf_d, of_q, of_d, zf_q, zf_d, valid_q, valid_d;

    // Debouncer: the counter only runs while the synchronized level disagrees
    // with the accepted level, so any agreeing cycle restarts the stability window.
    always_comb begin
        btn_meta_d      = btn;
        btn_s_d         = btn_meta_q;
        btn_clean_d     = btn_clean_q;
        db_cnt_d        = '0;
        if (btn_s_q != btn_clean_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_clean_d = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
        // Rising-edge detect one cycle behind btn_clean; falling edges are ignored.
        btn_clean_dly_d = btn_clean_q;
        press_d         = btn_clean_q & ~btn_clean_dly_q;
    end

    // Sequencer next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        res_d   = res_q;
        cf_d    = cf_q;
        of_d    = of_q;
        zf_d    = zf_q;
        valid_d = valid_q;
        case (state_q)
            LOAD_A: if (press_q) begin
                a_d     = din;
                valid_d = 1'b0;
                state_d = LOAD_B;
            end
            LOAD_B: if (press_q) begin
                b_d     = din;
                state_d = LOAD_S;
            end
            LOAD_S: if (press_q) begin
                s_d     = op_in;
                state_d = EXEC;
            end
            // a/b/s have been stable for this whole cycle, so the ALU has settled.
            EXEC: begin
                res_d   = y_in;
                cf_d    = cf_in;
                of_d    = of_in;
                zf_d    = zf_in;
                valid_d = 1'b1;
                state_d = SHOW;
            end
            SHOW: if (press_q) begin
                valid_d = 1'b0;
                if (chain) begin
                    a_d     = res_q;
                    state_d = LOAD_B;
                end else begin
                    state_d = LOAD_A;
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q      <= 1'b0;
            btn_s_q         <= 1'b0;
            btn_clean_q     <= 1'b0;
            btn_clean_dly_q <= 1'b0;
            db_cnt_q        <= '0;
            press_q         <= 1'b0;
            state_q         <= LOAD_A;
            a_q             <= '0;
            b_q             <= '0;
            s_q             <= '0;
            res_q           <= '0;
            cf_q            <= 1'b0;
            of_q            <= 1'b0;
            zf_q            <= 1'b0;
            valid_q         <= 1'b0;
        end else begin
            btn_meta_q      <= btn_meta_d;
            btn_s_q         <= btn_s_d;
            btn_clean_q     <= btn_clean_d;
            btn_clean_dly_q <= btn_clean_dly_d;
            db_cnt_q        <= db_cnt_d;
            press_q         <= press_d;
            state_q         <= state_d;
            a_q             <= a_d;
            b_q             <= b_d;
            s_q             <= s_d;
            res_q           <= res_d;
            cf_q            <= cf_d;
            of_q            <= of_d;
            zf_q            <= zf_d;
            valid_q         <= valid_d;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign s     = s_q;
    assign res   = res_q;
    assign cf    = cf_q;
    assign of    = of_q;
    assign zf    = zf_q;
    assign valid = valid_q;
    assign state = state_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Purpose : directed bench for alu_operand_seq with a behavioural ALU and a run-length/press-schedule model.
// Latency : model schedules each accepted press to act 4 edges after the DB_CYCLES-th stable raw sample.
// Backpr. : none; the bench drives inputs on the falling edge and compares on the falling edge.
module tb_alu_operand_seq;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [3:0] din = '0;
    logic [2:0] op_in = '0;
    logic       chain = 1'b0;
    logic [3:0] y_in;
    logic       cf_in, of_in, zf_in;
    logic [3:0] a, b, res;
    logic [2:0] s, state;
    logic       cf, of, zf, valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural 4-bit ALU: returns {y, cf, of, zf}.
    function automatic logic [6:0] alu(input logic [3:0] x, input logic [3:0] w, input logic [2:0] op);
        logic [4:0] sum;
        logic [3:0] y;
        logic       c, o;
        y = 4'd0; c = 1'b0; o = 1'b0;
        case (op)
            3'b000: begin
                sum = {1'b0, x} + {1'b0, w};
                y = sum[3:0]; c = sum[4];
                o = (x[3] == w[3]) && (y[3] != x[3]);
            end
            3'b001: begin
                y = x - w; c = (x < w);
                o = (x[3] != w[3]) && (y[3] != x[3]);
            end
            3'b010: y = x & w;
            3'b011: y = x | w;
            3'b100: y = x ^ w;
            default: y = 4'd0;
        endcase
        return {y, c, o, (y == 4'd0)};
    endfunction

    assign {y_in, cf_in, of_in, zf_in} = alu(a, b, s);

    alu_operand_seq #(.DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .btn(btn), .din(din), .op_in(op_in), .chain(chain),
        .y_in(y_in), .cf_in(cf_in), .of_in(of_in), .zf_in(zf_in),
        .a(a), .b(b), .s(s), .res(res), .cf(cf), .of(of), .zf(zf),
        .valid(valid), .state(state)
    );

    // Model: a press is accepted once the raw button has been sampled at a new
    // level DB times in a row; a rising acceptance acts 4 edges later.
    int          run_len;
    bit          m_level;
    longint      edge_no;
    longint      act_q[$];
    logic [3:0]  m_a, m_b, m_res;
    logic [2:0]  m_s, m_state;
    logic        m_cf, m_of, m_zf, m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run_len = 0; m_level = 1'b0; edge_no = 0; act_q.delete();
            m_a = '0; m_b = '0; m_s = '0; m_res = '0;
            m_cf = 1'b0; m_of = 1'b0; m_zf = 1'b0; m_valid = 1'b0; m_state = 3'd0;
        end else begin
            bit act;
            edge_no++;
            act = 1'b0;
            if (act_q.size() > 0 && act_q[0] == edge_no) begin
                act = 1'b1;
                void'(act_q.pop_front());
            end
            if (m_state == 3'd3) begin
                {m_res, m_cf, m_of, m_zf} = alu(m_a, m_b, m_s);
                m_valid = 1'b1;
                m_state = 3'd4;
            end else if (act) begin
                if (m_state == 3'd0) begin m_a = din; m_valid = 1'b0; m_state = 3'd1; end
                else if (m_state == 3'd1) begin m_b = din; m_state = 3'd2; end
                else if (m_state == 3'd2) begin m_s = op_in; m_state = 3'd3; end
                else begin
                    m_valid = 1'b0;
                    if (chain) begin m_a = m_res; m_state = 3'd1; end
                    else m_state = 3'd0;
                end
            end
            if (btn != m_level) begin
                run_len++;
                if (run_len == DB) begin
                    m_level = btn;
                    run_len = 0;
                    if (btn) act_q.push_back(edge_no + 4);
                end
            end else begin
                run_len = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ({a, b, s, res, cf, of, zf, valid, state} !==
                {m_a, m_b, m_s, m_res, m_cf, m_of, m_zf, m_valid, m_state}) begin
                errors++;
                $display("FAIL model_cycle t=%0t: got a=%h b=%h s=%h res=%h cf=%b of=%b zf=%b valid=%b state=%0d, expected a=%h b=%h s=%h res=%h cf=%b of=%b zf=%b valid=%b state=%0d",
                         $time, a, b, s, res, cf, of, zf, valid, state,
                         m_a, m_b, m_s, m_res, m_cf, m_of, m_zf, m_valid, m_state);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] d, input logic [2:0] op);
        din = d; op_in = op;
        @(negedge clk); btn = 1'b1;
        repeat (6) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", {5'd0, state}, 8'd0);
        chk("reset_valid", {7'd0, valid}, 8'd0);

        // 7 + 1: signed overflow, with edge-exact EXEC/SHOW timing on the opcode press.
        press(4'd7, 3'd0);
        press(4'd1, 3'd0);
        op_in = 3'b000;
        @(negedge clk); btn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 6) btn = 1'b0;
            if (k == 8) chk("exec_at_edge8", {5'd0, state}, 8'd3);
            if (k == 9) begin
                chk("show_at_edge9", {5'd0, state}, 8'd4);
                chk("valid_at_edge9", {7'd0, valid}, 8'd1);
            end
        end
        repeat (12) @(negedge clk);
        chk("add_res", {4'd0, res}, 8'd8);
        chk("add_flags_cf_of_zf", {5'd0, cf, of, zf}, 8'b010);

        // Chain: result 8 becomes A, then 8 - 8 = 0.
        chain = 1'b1;
        press(4'd0, 3'd0);
        chain = 1'b0;
        chk("chain_a", {4'd0, a}, 8'd8);
        chk("chain_state", {5'd0, state}, 8'd1);
        chk("chain_valid", {7'd0, valid}, 8'd0);
        press(4'd8, 3'd0);
        press(4'd0, 3'd1);
        chk("chain_sub_res", {4'd0, res}, 8'd0);
        chk("chain_sub_flags", {5'd0, cf, of, zf}, 8'b001);

        // Back to LOAD_A without chaining, then 2 - 3 borrows.
        press(4'd0, 3'd0);
        chk("unchained_state", {5'd0, state}, 8'd0);
        press(4'd2, 3'd0);
        press(4'd3, 3'd0);
        press(4'd0, 3'd1);
        chk("borrow_res", {4'd0, res}, 8'd15);
        chk("borrow_flags", {5'd0, cf, of, zf}, 8'b100);

        // Debounce: short glitch, long hold with a low glitch, release.
        press(4'd0, 3'd0);
        chk("to_load_a", {5'd0, state}, 8'd0);
        @(negedge clk); btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_no_advance", {5'd0, state}, 8'd0);
        din = 4'd5;
        @(negedge clk); btn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 7) chk("held_edge7_no_advance", {5'd0, state}, 8'd0);
            if (k == 8) chk("held_edge8_advance", {5'd0, state}, 8'd1);
            if (k == 10) btn = 1'b0;
            if (k == 12) btn = 1'b1;
        end
        btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_single_advance", {5'd0, state}, 8'd1);
        chk("held_a", {4'd0, a}, 8'd5);

        // Reset mid-sequence with the button held through release.
        press(4'd3, 3'd0);
        chk("pre_reset_state", {5'd0, state}, 8'd2);
        chk("pre_reset_b", {4'd0, b}, 8'd3);
        din = 4'd9;
        @(negedge clk); btn = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_reset_state", {5'd0, state}, 8'd0);
        chk("async_reset_ab", {a, b}, 8'd0);
        chk("async_reset_res_s", {1'b0, res, s}, 8'd0);
        chk("async_reset_flags", {4'd0, cf, of, zf, valid}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_reset_state", {5'd0, state}, 8'd1);
        chk("post_reset_a", {4'd0, a}, 8'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
